// File: rtl/game_lives_ctrl_if.sv
// Bundle of the lives controller's pixel/pickup inputs and status outputs.
// master: game-logic side that drives the inputs. slave: the controller.
interface game_lives_ctrl_if #(
    parameter int LIVES_W = 3
);
    logic               bm_hb_on;
    logic               enemy_on;
    logic               exp_on;
    logic               life_up;
    logic               restart;
    logic [LIVES_W-1:0] lives;
    logic               gameover;
    logic               invuln;
    logic               hit_pulse;
    logic               bm_visible;
    logic [11:0]        background_rgb;

    modport master (
        output bm_hb_on, enemy_on, exp_on, life_up, restart,
        input  lives, gameover, invuln, hit_pulse, bm_visible, background_rgb
    );

    modport slave (
        input  bm_hb_on, enemy_on, exp_on, life_up, restart,
        output lives, gameover, invuln, hit_pulse, bm_visible, background_rgb
    );
endinterface

// File: rtl/game_lives_ctrl.sv
// Lives / invulnerability controller: loses a life on hitbox overlap with an
// enemy or explosion pixel, then runs a fixed-length invulnerability window
// with a blinking sprite. Handles extra-life pickups, game over and restart.
// Every output is a register or a decode of registers.
module game_lives_ctrl #(
    parameter int MAX_LIVES     = 5,
    parameter int START_LIVES   = 5,
    parameter int LIVES_W       = 3,
    parameter int INVULN_CYCLES = 150000000,
    parameter int CNT_W         = 28,
    parameter int BLINK_BIT     = 22
) (
    input  logic               clk,
    input  logic               reset,
    game_lives_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        INVULN = 2'd1,
        OVER   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit_pulse_q, hit_pulse_d;

    logic               hit;
    logic [LIVES_W:0]   inc_sum;
    logic [LIVES_W-1:0] lives_inc;
    logic [LIVES_W+4:0] red_dbl;
    logic [3:0]         red;

    assign hit = bus.bm_hb_on & (bus.enemy_on | bus.exp_on);

    // Lives adder is one bit wider so the saturation check sees the carry
    assign inc_sum   = {1'b0, lives_q} + (LIVES_W+1)'(1);
    assign lives_inc = (inc_sum > (LIVES_W+1)'(MAX_LIVES)) ? LIVES_W'(MAX_LIVES)
                                                           : inc_sum[LIVES_W-1:0];

    // State, lives, window counter and hit pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PLAY;
            lives_q     <= LIVES_W'(START_LIVES);
            cnt_q       <= '0;
            hit_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            hit_pulse_q <= hit_pulse_d;
        end
    end

    // Next-state logic; restart outranks hit and life_up in every state
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        hit_pulse_d = 1'b0;
        if (bus.restart) begin
            state_d = PLAY;
            lives_d = LIVES_W'(START_LIVES);
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (hit) begin
                        hit_pulse_d = 1'b1;
                        cnt_d       = '0;
                        if (bus.life_up) begin
                            // pickup cancels the loss; still take the window
                            state_d = INVULN;
                        end else if (lives_q == LIVES_W'(1)) begin
                            lives_d = '0;
                            state_d = OVER;
                        end else begin
                            lives_d = lives_q - LIVES_W'(1);
                            state_d = INVULN;
                        end
                    end else if (bus.life_up) begin
                        lives_d = lives_inc;
                    end
                end
                INVULN: begin
                    if (bus.life_up) lives_d = lives_inc;
                    if (cnt_q == CNT_W'(INVULN_CYCLES - 1)) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OVER: begin
                    lives_d = '0;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = PLAY;
                    lives_d = LIVES_W'(START_LIVES);
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Frame colour: red channel tracks 2*lives, clamped to 4 bits
    always_comb begin
        red_dbl = (LIVES_W+5)'(lives_q) << 1;
        red     = (red_dbl > (LIVES_W+5)'(15)) ? 4'hF : red_dbl[3:0];
    end

    assign bus.lives          = lives_q;
    assign bus.gameover       = (state_q == OVER);
    assign bus.invuln         = (state_q == INVULN);
    assign bus.hit_pulse      = hit_pulse_q;
    assign bus.bm_visible     = (state_q == PLAY) |
                                ((state_q == INVULN) & ~cnt_q[BLINK_BIT]);
    assign bus.background_rgb = {red, 8'h00};

endmodule

// File: tb/tb_game_lives_ctrl.sv
// Directed bench for game_lives_ctrl with a short 8-cycle invulnerability
// window and blink on counter bit 1.
module tb_game_lives_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    game_lives_ctrl_if #(.LIVES_W(3)) bus ();

    game_lives_ctrl #(
        .MAX_LIVES(5), .START_LIVES(5), .LIVES_W(3),
        .INVULN_CYCLES(8), .CNT_W(28), .BLINK_BIT(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // advance one clock; outputs are stable 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.bm_hb_on = 0; bus.enemy_on = 0; bus.exp_on = 0;
        bus.life_up  = 0; bus.restart  = 0;
    endtask

    // single-cycle enemy hit, check the result, then sit out the window
    task automatic hit_once(input string tag, input int exp_lives);
        bus.bm_hb_on = 1; bus.enemy_on = 1;
        tick();
        clr();
        chk({tag, "_lives"}, bus.lives, exp_lives);
        chk({tag, "_pulse"}, bus.hit_pulse, 1);
        chk({tag, "_rgb"}, bus.background_rgb, exp_lives * 2 * 256);
        repeat (9) tick();
    endtask

    initial begin
        int hp_seen, inv_cnt, hp_cnt;
        logic [7:0] vis;
        n_chk = 0; n_pass = 0;
        clr();
        reset = 1;
        tick();
        reset = 0;

        // reset state
        chk("rst_lives", bus.lives, 5);
        chk("rst_over", bus.gameover, 0);
        chk("rst_invuln", bus.invuln, 0);
        chk("rst_pulse", bus.hit_pulse, 0);
        chk("rst_vis", bus.bm_visible, 1);
        chk("rst_rgb", bus.background_rgb, 12'hA00);

        // hitbox gating
        hp_seen = 0;
        bus.enemy_on = 1;
        for (int i = 0; i < 100; i++) begin tick(); hp_seen |= bus.hit_pulse; end
        bus.enemy_on = 0; bus.bm_hb_on = 1;
        for (int i = 0; i < 10; i++) begin tick(); hp_seen |= bus.hit_pulse; end
        clr();
        chk("gate_pulse", hp_seen, 0);
        chk("gate_lives", bus.lives, 5);
        chk("gate_invuln", bus.invuln, 0);

        // life_up saturates at MAX_LIVES
        bus.life_up = 1; tick(); clr();
        chk("sat_lives", bus.lives, 5);

        // held explosion hit: one decrement, 8-cycle window, blink, re-hit
        bus.bm_hb_on = 1; bus.exp_on = 1;
        inv_cnt = 0; hp_cnt = 0; vis = '0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            inv_cnt += bus.invuln;
            hp_cnt  += bus.hit_pulse;
            if (i == 1) chk("win_lives", bus.lives, 4);
            if (i <= 8) vis[i-1] = bus.bm_visible;
        end
        chk("win_invuln_len", inv_cnt, 8);
        chk("win_pulse_cnt", hp_cnt, 1);
        chk("win_blink", vis, 8'b0011_0011);
        chk("win_back_play", bus.invuln, 0);
        tick();
        chk("win_rehit_lives", bus.lives, 3);
        chk("win_rehit_pulse", bus.hit_pulse, 1);
        clr();
        repeat (10) tick();
        bus.restart = 1; tick(); clr();
        chk("rs_lives", bus.lives, 5);

        // reset mid-game after two hits
        hit_once("mg1", 4);
        hit_once("mg2", 3);
        reset = 1; tick(); reset = 0;
        chk("mg_lives", bus.lives, 5);
        chk("mg_over", bus.gameover, 0);
        chk("mg_invuln", bus.invuln, 0);
        chk("mg_vis", bus.bm_visible, 1);
        chk("mg_rgb", bus.background_rgb, 12'hA00);

        // game over
        hit_once("go1", 4);
        hit_once("go2", 3);
        hit_once("go3", 2);
        hit_once("go4", 1);
        bus.bm_hb_on = 1; bus.enemy_on = 1;
        tick();
        chk("go5_lives", bus.lives, 0);
        chk("go5_pulse", bus.hit_pulse, 1);
        chk("go_over", bus.gameover, 1);
        chk("go_rgb", bus.background_rgb, 12'h000);
        chk("go_vis", bus.bm_visible, 0);
        chk("go_invuln", bus.invuln, 0);
        bus.life_up = 1;
        hp_seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); hp_seen |= bus.hit_pulse; end
        chk("go_hold_lives", bus.lives, 0);
        chk("go_hold_pulse", hp_seen, 0);
        bus.life_up = 0;

        // restart beats hit in OVER
        bus.restart = 1;
        tick();
        clr();
        chk("ro_lives", bus.lives, 5);
        chk("ro_over", bus.gameover, 0);
        chk("ro_invuln", bus.invuln, 0);
        chk("ro_pulse", bus.hit_pulse, 0);

        // hit and life_up together at one life
        hit_once("c1", 4);
        hit_once("c2", 3);
        hit_once("c3", 2);
        hit_once("c4", 1);
        bus.bm_hb_on = 1; bus.enemy_on = 1; bus.life_up = 1;
        tick();
        clr();
        chk("co_lives", bus.lives, 1);
        chk("co_pulse", bus.hit_pulse, 1);
        chk("co_invuln", bus.invuln, 1);
        chk("co_over", bus.gameover, 0);

        // restart out of INVULN
        repeat (2) tick();
        bus.restart = 1; tick(); clr();
        chk("ri_invuln", bus.invuln, 0);
        chk("ri_lives", bus.lives, 5);
        chk("ri_vis", bus.bm_visible, 1);

        // life_up during INVULN, then a fresh full-length window
        bus.bm_hb_on = 1; bus.enemy_on = 1;
        tick();
        clr();
        inv_cnt = bus.invuln;
        bus.life_up = 1; tick(); clr();
        chk("iu_lives", bus.lives, 5);
        inv_cnt += bus.invuln;
        for (int i = 0; i < 10; i++) begin tick(); inv_cnt += bus.invuln; end
        chk("iu_win_len", inv_cnt, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/game_lives_ctrl.md
Name: game_lives_ctrl

Overview:
Parametrised lives/invulnerability controller for bomberman. Detects hitbox overlap with enemy or explosion pixels, decrements lives, and runs a timed invulnerability window with a sprite-blink output. Also handles extra-life pickups, game-over, and restart. Sits between the pixel generators (hitbox, enemy, explosion) and the bomberman/bomb/arena modules, which consume gameover, bm_visible and background_rgb.

Parameters:
MAX_LIVES, 5, saturation ceiling for lives (1..2^LIVES_W-1)
START_LIVES, 5, lives loaded on reset/restart (1..MAX_LIVES)
LIVES_W, 3, width of lives count
INVULN_CYCLES, 150000000, invulnerability duration in clk cycles (>=2, < 2^CNT_W)
CNT_W, 28, invulnerability counter width
BLINK_BIT, 22, counter bit driving sprite blink (< CNT_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
bm_hb_on  in  1  current pixel is inside bomberman hitbox
enemy_on  in  1  current pixel is an enemy pixel
exp_on  in  1  current pixel is an explosion pixel
life_up  in  1  one-cycle pulse: extra-life pickup collected
restart  in  1  one-cycle pulse: start a new game
lives  out  LIVES_W  current lives count
gameover  out  1  high while in OVER state
invuln  out  1  high while in INVULN state
hit_pulse  out  1  one-cycle pulse when a life is lost
bm_visible  out  1  bomberman sprite enable (blink during invulnerability)
background_rgb  out  12  arena frame colour {R[3:0],G[3:0],B[3:0]}

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on posedge clk.
- hit = bm_hb_on & (enemy_on | exp_on), sampled every cycle.
- Reset values: state=PLAY, lives=START_LIVES, counter=0, gameover=0, invuln=0, hit_pulse=0, bm_visible=1, background_rgb from START_LIVES.
- States: PLAY, INVULN, OVER. All outputs are registered or decoded from registers; no combinational input-to-output paths.
- PLAY, hit and no life_up:
  - lives <= lives-1 and hit_pulse <= 1 (visible the cycle after hit is sampled).
  - If lives was 1, go to OVER; otherwise go to INVULN with counter=0.
- PLAY, hit and life_up in the same cycle:
  - Net lives unchanged. hit_pulse=1. Go to INVULN with counter=0, even if lives==1.
- INVULN:
  - counter increments every cycle and hits are ignored.
  - When counter==INVULN_CYCLES-1, go to PLAY and set counter=0, so the window is exactly INVULN_CYCLES cycles.
- life_up in PLAY (no hit) or INVULN: lives <= min(lives+1, MAX_LIVES). Saturates silently.
- OVER:
  - lives=0, gameover=1.
  - hit and life_up are ignored; counter is held at 0.
- restart in any state: the next cycle equals the post-reset condition. restart has priority over hit and life_up in the same cycle.
- hit_pulse is high for exactly one cycle per life lost and is 0 in all other cycles.
- invuln is 1 only in INVULN.
- bm_visible:
  - PLAY: 1.
  - INVULN: ~counter[BLINK_BIT].
  - OVER: 0.
- background_rgb: R = min(2*lives, 15), G = B = 0. With defaults: 5→0xA00, 4→0x800, 3→0x600, 2→0x400, 1→0x200, 0→0x000.
- Arithmetic: the lives adder is LIVES_W+1 bits internally. No wrap below 0 or above MAX_LIVES.

Test Plan:
(All scenarios use INVULN_CYCLES=8, BLINK_BIT=1, defaults otherwise.)
1. Reset mid-game: after 2 hits, assert reset for 1 cycle → next cycle lives=5, state PLAY, gameover=0, bm_visible=1, background_rgb=0xA00.
2. Single hit and window length: hold bm_hb_on=1, exp_on=1 for 20 cycles.
   - lives=4, hit_pulse high for exactly 1 cycle, invuln high for exactly 8 cycles.
   - bm_visible toggles every 2 cycles during the window.
   - A second decrement to 3 occurs on the first cycle back in PLAY.
3. Game over: 5 separated hits (enemy_on & bm_hb_on) → lives 4,3,2,1,0; after the 5th hit gameover=1, background_rgb=0x000, bm_visible=0. Further hits and life_up leave lives=0.
4. Extra-life saturation and coincidence:
   - life_up at lives=5 → lives stays 5.
   - At lives=1 in PLAY, hit and life_up in the same cycle → lives=1, hit_pulse=1, invuln=1, gameover=0.
5. Restart priority: in OVER, pulse restart together with hit → lives=5, PLAY, hit_pulse=0. In INVULN, restart → invuln=0 next cycle, counter=0.
6. Hitbox gating: enemy_on=1 with bm_hb_on=0 for 100 cycles, then bm_hb_on=1 with both enemy_on=0 and exp_on=0 → no change, lives=5, hit_pulse never asserted.
